// File: rtl/core_pkg.sv
// core_pkg: forwarding-select codes and hazard FSM state shared by the core control logic
package core_pkg;
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;
  typedef enum logic [1:0] {RUN, MEM_WAIT, BUS_ERR} hz_state_t;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: priority forwarding selector for one source operand, nearest producer wins
module fwd_sel
  import core_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] ex_dst,
  input  logic [4:0] mem_dst,
  input  logic [4:0] wb_dst,
  input  logic       ex_regwrite,
  input  logic       mem_regwrite,
  input  logic       wb_regwrite,
  output logic [1:0] sel
);
  assign sel = src == 5'd0                        ? FWD_REG :
               ex_regwrite  && ex_dst  == src     ? FWD_EX  :
               mem_regwrite && mem_dst == src     ? FWD_MEM :
               wb_regwrite  && wb_dst  == src     ? FWD_WB  : FWD_REG;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stalls, redirect flushes, data-memory waits and timeout halt
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_dst,
  input  logic [4:0]  mem_dst,
  input  logic [4:0]  wb_dst,
  input  logic        ex_regwrite,
  input  logic        mem_regwrite,
  input  logic        wb_regwrite,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic [1:0]  ctrl_rs,
  output logic [1:0]  ctrl_rt,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        id_we,
  output logic        ifid_flush,
  output logic        id_flush,
  output logic        bus_error,
  output logic [31:0] stall_count
);
  hz_state_t   state, state_n;
  logic [15:0] wcnt, wcnt_n;
  logic [1:0]  rs_sel, rt_sel;
  logic        load_use, frozen, run;

  fwd_sel u_fwd_rs (.src(id_rs), .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
                    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
                    .wb_regwrite(wb_regwrite), .sel(rs_sel));
  fwd_sel u_fwd_rt (.src(id_rt), .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
                    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
                    .wb_regwrite(wb_regwrite), .sel(rt_sel));

  assign load_use = ex_mem_read && ex_dst != 5'd0 && (ex_dst == id_rs || ex_dst == id_rt);
  // The pipe is frozen whenever a data access is outstanding or the bus has failed
  assign frozen   = state == BUS_ERR || (state == RUN ? mem_req && !mem_ready : !mem_ready);
  assign run      = reset && !frozen;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      wcnt        <= '0;
      stall_count <= '0;
    end else begin
      state       <= state_n;
      wcnt        <= wcnt_n;
      stall_count <= !pc_we && stall_count != 32'hFFFF_FFFF ? stall_count + 32'd1 : stall_count;
    end
  end

  // Counter holds completed wait cycles, so the cycle being evaluated is wcnt+1
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    case (state)
      RUN: if (mem_req && !mem_ready) begin
        state_n = MEM_TIMEOUT == 1 ? BUS_ERR : MEM_WAIT;
        wcnt_n  = 16'd1;
      end
      MEM_WAIT: if (mem_ready) begin
        state_n = RUN;
        wcnt_n  = '0;
      end else if (wcnt >= 16'(MEM_TIMEOUT - 1)) begin
        state_n = BUS_ERR;
      end else begin
        wcnt_n  = wcnt + 16'd1;
      end
      default: state_n = BUS_ERR;
    endcase
  end

  always_comb begin
    ctrl_rs    = reset ? rs_sel : FWD_REG;
    ctrl_rt    = reset ? rt_sel : FWD_REG;
    pc_we      = run && (ex_redirect || !load_use);
    ifid_we    = run && (ex_redirect || !load_use);
    id_we      = run;
    ifid_flush = !reset || (run && ex_redirect);
    id_flush   = !reset || (run && (ex_redirect || load_use));
    bus_error  = reset && state == BUS_ERR;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench with directed and random stimulus against a cycle-level reference model
module tb_hazard_ctrl;
  localparam int TO = 4;
  logic        clk = 0, reset;
  logic [4:0]  id_rs, id_rt, ex_dst, mem_dst, wb_dst;
  logic        ex_regwrite, mem_regwrite, wb_regwrite, ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic [1:0]  ctrl_rs, ctrl_rt;
  logic        pc_we, ifid_we, id_we, ifid_flush, id_flush, bus_error;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_dst(ex_dst), .mem_dst(mem_dst),
    .wb_dst(wb_dst), .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .ctrl_rs(ctrl_rs), .ctrl_rt(ctrl_rt), .pc_we(pc_we), .ifid_we(ifid_we), .id_we(id_we),
    .ifid_flush(ifid_flush), .id_flush(id_flush), .bus_error(bus_error), .stall_count(stall_count)
  );

  typedef struct packed {
    logic [1:0]  rs, rt;
    logic        pc, ifid, id, fi, fd, be;
    logic [31:0] sc;
  } exp_t;

  exp_t   q[$];
  int     compared = 0, mismatched = 0;
  int     waited = 0;
  bit     dead = 0;
  longint cnt = 0;

  function automatic logic [1:0] fwd(input logic [4:0] s, input logic [4:0] ed, md, wd,
                                     input logic erw, mrw, wrw);
    logic [4:0] d[3];
    logic       w[3];
    d = '{ed, md, wd};
    w = '{erw, mrw, wrw};
    if (s == 0) return 2'd0;
    for (int i = 0; i < 3; i++) if (w[i] && d[i] == s) return 2'(i + 1);
    return 2'd0;
  endfunction

  task automatic step(input logic rst, input logic [4:0] rs, rt, ed, md, wd,
                      input logic erw, mrw, wrw, emr, red, mreq, mrdy);
    exp_t e;
    bit   blocked, lu;
    reset = rst; id_rs = rs; id_rt = rt; ex_dst = ed; mem_dst = md; wb_dst = wd;
    ex_regwrite = erw; mem_regwrite = mrw; wb_regwrite = wrw; ex_mem_read = emr;
    ex_redirect = red; mem_req = mreq; mem_ready = mrdy;
    e = '0;
    e.sc = cnt[31:0];
    if (!rst) begin
      e.fi = 1; e.fd = 1;
      waited = 0; dead = 0; cnt = 0;
    end else begin
      e.rs = fwd(rs, ed, md, wd, erw, mrw, wrw);
      e.rt = fwd(rt, ed, md, wd, erw, mrw, wrw);
      e.be = dead;
      if (!dead) begin
        blocked = waited > 0 ? !mrdy : (mreq && !mrdy);
        if (blocked) begin
          waited++;
          if (waited == TO) dead = 1;
        end else begin
          waited = 0;
          lu = emr && ed != 0 && (ed == rs || ed == rt);
          e.pc = red || !lu; e.ifid = red || !lu; e.id = 1;
          e.fi = red; e.fd = red || lu;
        end
      end
      if (!e.pc && cnt < 64'hFFFF_FFFF) cnt++;
    end
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        a = {ctrl_rs, ctrl_rt, pc_we, ifid_we, id_we, ifid_flush, id_flush, bus_error, stall_count};
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL outputs t=%0t got rs=%0d rt=%0d pc=%b ifid=%b id=%b fi=%b fd=%b be=%b sc=%0d want rs=%0d rt=%0d pc=%b ifid=%b id=%b fi=%b fd=%b be=%b sc=%0d",
                   $time, a.rs, a.rt, a.pc, a.ifid, a.id, a.fi, a.fd, a.be, a.sc,
                   e.rs, e.rt, e.pc, e.ifid, e.id, e.fi, e.fd, e.be, e.sc);
        end
      end
    end
  end

  initial begin
    reset = 0; id_rs = 0; id_rt = 0; ex_dst = 0; mem_dst = 0; wb_dst = 0;
    ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0; ex_mem_read = 0;
    ex_redirect = 0; mem_req = 0; mem_ready = 1;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 3, 4, 3, 4, 0, 1, 1, 0, 0, 0, 0, 1);
    idle(1);
    step(1, 5, 0, 5, 5, 0, 1, 1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 0, 1);
    step(1, 7, 7, 1, 2, 7, 1, 1, 1, 0, 0, 0, 1);
    step(1, 1, 8, 8, 0, 0, 1, 0, 0, 1, 0, 0, 1);
    step(1, 1, 8, 0, 8, 0, 0, 1, 0, 0, 0, 0, 1);
    step(1, 8, 2, 8, 0, 0, 1, 0, 0, 1, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 2, 3, 2, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    step(1, 2, 3, 2, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 4, 0, 4, 0, 0, 1, 0, 0, 1, 1, 1, 1);
    idle(1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 6, 6, 6, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 39) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < (i < 1500 ? 70 : 40));
    repeat (3) @(negedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
